// File: rtl/cam_capture_writer.sv
// cam_capture_writer
//   Captures 8-bit camera pixels (two bytes per pixel), subsamples them by
//   DECIM in both axes and writes 16-bit formatted pixels into one of two
//   frame-buffer banks. Bank ownership is handed to a reader via Frame_Done_o
//   and returned with Frame_Ack_i. When no bank is free, the frame is
//   dropped and counted.
// Ports:
//   Clk_i, Reset_i (async, active-low)       pixel clock and reset
//   Enable_i                                 capture enable
//   Vsync_i, Href_i, Data_i                  camera timing and byte bus
//   Mode_i                                   00 RGB565, 01 RGB444, 10 Y8, 11 as 00
//   Frame_Ack_i, Ack_Bank_i                  reader releases a bank
//   Wr_En_o, Wr_Bank_o, Wr_Addr_o, Wr_Data_o frame-buffer write port
//   Frame_Done_o, Ready_Bank_o               completed-frame pulse and its bank
//   Frame_Err_o                              aborted-frame pulse
//   Overrun_o, Dropped_o                     sticky drop flag, saturating drop count
module cam_capture_writer #(
    parameter int unsigned SRC_W  = 640,
    parameter int unsigned SRC_H  = 480,
    parameter int unsigned DECIM  = 4,
    parameter int unsigned ADDR_W = 15
) (
    input  logic              Clk_i,
    input  logic              Reset_i,
    input  logic              Enable_i,
    input  logic              Vsync_i,
    input  logic              Href_i,
    input  logic [7:0]        Data_i,
    input  logic [1:0]        Mode_i,
    input  logic              Frame_Ack_i,
    input  logic              Ack_Bank_i,
    output logic              Wr_En_o,
    output logic              Wr_Bank_o,
    output logic [ADDR_W-1:0] Wr_Addr_o,
    output logic [15:0]       Wr_Data_o,
    output logic              Frame_Done_o,
    output logic              Ready_Bank_o,
    output logic              Frame_Err_o,
    output logic              Overrun_o,
    output logic [7:0]        Dropped_o
);

    localparam int unsigned COL_W = $clog2(SRC_W + 1);
    localparam int unsigned ROW_W = $clog2(SRC_H + 1);
    localparam logic [COL_W-1:0] COL_MAX  = COL_W'(SRC_W);
    localparam logic [ROW_W-1:0] ROW_MAX  = ROW_W'(SRC_H);
    // DECIM is a power of two, so "mod DECIM" is a mask of the low bits.
    localparam logic [COL_W-1:0] COL_MASK = COL_W'(DECIM - 1);
    localparam logic [ROW_W-1:0] ROW_MASK = ROW_W'(DECIM - 1);

    typedef enum logic [1:0] {IDLE, WAIT_VS, CAPTURE, DROP} state_t;

    state_t             state_q;
    logic               vs_q, vs_d1_q, href_q, href_d1_q;
    logic [7:0]         data_q, b1_q;
    logic               phase_q;
    logic [1:0]         mode_q;
    logic [COL_W-1:0]   col_q;
    logic [ROW_W-1:0]   row_q;
    logic [ADDR_W-1:0]  addr_q;
    logic               cur_bank_q, ready_q;
    logic [1:0]         full_q, full_d;
    logic               wr_en_q, wr_bank_q, done_q, err_q, overrun_q;
    logic [ADDR_W-1:0]  wr_addr_q;
    logic [15:0]        wr_data_q, pix_fmt;
    logic [7:0]         dropped_q;

    logic vs_rise, vs_fall, href_fall, tgt_bank, done_now, pix_keep;

    assign vs_rise   = vs_q & ~vs_d1_q;
    assign vs_fall   = ~vs_q & vs_d1_q;
    assign href_fall = ~href_q & href_d1_q;
    assign tgt_bank  = ~ready_q;
    assign done_now  = Enable_i && (state_q == CAPTURE) && vs_rise && (row_q == ROW_MAX);
    assign pix_keep  = (col_q < COL_MAX) && (row_q < ROW_MAX) &&
                       ((col_q & COL_MASK) == '0) && ((row_q & ROW_MASK) == '0);

    always_comb begin
        case (mode_q)
            2'b01:   pix_fmt = {4'h0, b1_q[3:0], data_q};
            2'b10:   pix_fmt = {8'h00, b1_q};
            default: pix_fmt = {b1_q, data_q};
        endcase
    end

    // Completion and release may land in the same cycle; an ack naming the
    // bank being captured is ignored, so the two never target the same flag.
    always_comb begin
        full_d = full_q;
        if (done_now)
            full_d[cur_bank_q] = 1'b1;
        if (Frame_Ack_i && !((state_q == CAPTURE) && (Ack_Bank_i == cur_bank_q)))
            full_d[Ack_Bank_i] = 1'b0;
    end

    always_ff @(posedge Clk_i or negedge Reset_i) begin
        if (!Reset_i) begin
            state_q    <= IDLE;
            vs_q       <= 1'b0;
            vs_d1_q    <= 1'b0;
            href_q     <= 1'b0;
            href_d1_q  <= 1'b0;
            data_q     <= '0;
            b1_q       <= '0;
            phase_q    <= 1'b0;
            mode_q     <= '0;
            col_q      <= '0;
            row_q      <= '0;
            addr_q     <= '0;
            cur_bank_q <= 1'b0;
            ready_q    <= 1'b1;
            full_q     <= '0;
            wr_en_q    <= 1'b0;
            wr_bank_q  <= 1'b0;
            wr_addr_q  <= '0;
            wr_data_q  <= '0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
            overrun_q  <= 1'b0;
            dropped_q  <= '0;
        end else begin
            vs_q      <= Vsync_i;
            vs_d1_q   <= vs_q;
            href_q    <= Href_i;
            href_d1_q <= href_q;
            data_q    <= Data_i;
            full_q    <= full_d;
            wr_en_q   <= 1'b0;
            done_q    <= 1'b0;
            err_q     <= 1'b0;

            phase_q <= href_q ? ~phase_q : 1'b0;
            if (href_q && !phase_q)
                b1_q <= data_q;

            if (!Enable_i) begin
                if (state_q == CAPTURE)
                    err_q <= 1'b1;
                state_q <= IDLE;
            end else begin
                case (state_q)
                    IDLE: state_q <= WAIT_VS;
                    WAIT_VS: begin
                        if (vs_fall) begin
                            cur_bank_q <= tgt_bank;
                            mode_q     <= Mode_i;
                            col_q      <= '0;
                            row_q      <= '0;
                            addr_q     <= '0;
                            state_q    <= full_q[tgt_bank] ? DROP : CAPTURE;
                        end
                    end
                    CAPTURE: begin
                        if (vs_rise) begin
                            if (row_q == ROW_MAX) begin
                                ready_q <= cur_bank_q;
                                done_q  <= 1'b1;
                            end else begin
                                err_q <= 1'b1;
                            end
                            state_q <= WAIT_VS;
                        end else begin
                            if (href_q && phase_q) begin
                                if (col_q != COL_MAX)
                                    col_q <= col_q + 1'b1;
                                if (pix_keep) begin
                                    wr_en_q   <= 1'b1;
                                    wr_bank_q <= cur_bank_q;
                                    wr_addr_q <= addr_q;
                                    wr_data_q <= pix_fmt;
                                    addr_q    <= addr_q + 1'b1;
                                end
                            end
                            if (href_fall) begin
                                col_q <= '0;
                                if (row_q != ROW_MAX)
                                    row_q <= row_q + 1'b1;
                            end
                        end
                    end
                    DROP: begin
                        if (vs_rise) begin
                            overrun_q <= 1'b1;
                            if (dropped_q != 8'hFF)
                                dropped_q <= dropped_q + 8'd1;
                            state_q <= WAIT_VS;
                        end
                    end
                    default: state_q <= IDLE;
                endcase
            end
        end
    end

    assign Wr_En_o      = wr_en_q;
    assign Wr_Bank_o    = wr_bank_q;
    assign Wr_Addr_o    = wr_addr_q;
    assign Wr_Data_o    = wr_data_q;
    assign Frame_Done_o = done_q;
    assign Ready_Bank_o = ready_q;
    assign Frame_Err_o  = err_q;
    assign Overrun_o    = overrun_q;
    assign Dropped_o    = dropped_q;

endmodule

// File: tb/tb_cam_capture_writer.sv
// tb_cam_capture_writer
//   Directed bench for cam_capture_writer with SRC_W=8, SRC_H=4, DECIM=2,
//   ADDR_W=3. Expected writes (bank, address, data, cycle) are queued as the
//   camera bytes are driven and popped when Wr_En_o is seen.
module tb_cam_capture_writer;

    localparam int W  = 8;
    localparam int H  = 4;
    localparam int D  = 2;
    localparam int AW = 3;

    logic          clk = 1'b0;
    logic          rst_n, en, vs, href, ack, ack_bank;
    logic [7:0]    data;
    logic [1:0]    mode;
    logic          wr_en, wr_bank, done, ready, err, overrun;
    logic [AW-1:0] wr_addr;
    logic [15:0]   wr_data;
    logic [7:0]    dropped;

    always #5 clk = ~clk;

    cam_capture_writer #(.SRC_W(W), .SRC_H(H), .DECIM(D), .ADDR_W(AW)) dut (
        .Clk_i(clk), .Reset_i(rst_n), .Enable_i(en), .Vsync_i(vs), .Href_i(href),
        .Data_i(data), .Mode_i(mode), .Frame_Ack_i(ack), .Ack_Bank_i(ack_bank),
        .Wr_En_o(wr_en), .Wr_Bank_o(wr_bank), .Wr_Addr_o(wr_addr), .Wr_Data_o(wr_data),
        .Frame_Done_o(done), .Ready_Bank_o(ready), .Frame_Err_o(err),
        .Overrun_o(overrun), .Dropped_o(dropped)
    );

    typedef struct {
        logic          bank;
        logic [AW-1:0] addr;
        logic [15:0]   data;
        int            cyc;
    } exp_t;

    exp_t       sbq[$];
    int         checks = 0, failures = 0;
    int         cyc = 0, done_cnt = 0, err_cnt = 0, wr_cnt = 0;
    logic [7:0] fr_bytes[64];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [15:0] fmt(input logic [1:0] m, input logic [7:0] b1, input logic [7:0] b2);
        if (m == 2'b01)      return {4'h0, b1[3:0], b2};
        else if (m == 2'b10) return {8'h00, b1};
        else                 return {b1, b2};
    endfunction

    always @(negedge clk) begin
        if (done) done_cnt++;
        if (err)  err_cnt++;
        if (wr_en) begin
            exp_t e;
            wr_cnt++;
            chk("wr_expected", 32'(sbq.size() != 0), 32'd1);
            if (sbq.size() != 0) begin
                e = sbq.pop_front();
                chk("wr_bank", 32'(wr_bank), 32'(e.bank));
                chk("wr_addr", 32'(wr_addr), 32'(e.addr));
                chk("wr_data", 32'(wr_data), 32'(e.data));
                chk("wr_cycle", 32'(cyc), 32'(e.cyc));
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic frame_ack(input logic b);
        ack_bank = b;
        ack = 1'b1;
        tick();
        ack = 1'b0;
    endtask

    // abort_kind: 1 drops Enable, 2 asserts reset, at byte index abort_at.
    task automatic send_frame(input int lines, input logic [1:0] m, input logic bank,
                              input bit capture, input int abort_at, input int abort_kind);
        int addr;
        int idx;
        logic [7:0] b1;
        addr = 0;
        b1 = '0;
        mode = m;
        vs = 1'b1;
        repeat (4) tick();
        vs = 1'b0;
        repeat (3) tick();
        mode = m ^ 2'b10;
        for (int r = 0; r < lines; r++) begin
            for (int i = 0; i < 2 * W; i++) begin
                idx = r * 2 * W + i;
                if (idx == abort_at) begin
                    if (abort_kind == 1) en = 1'b0;
                    else                 rst_n = 1'b0;
                    return;
                end
                href = 1'b1;
                data = fr_bytes[idx];
                if (i % 2 == 0) begin
                    b1 = data;
                end else if (capture && (r % D == 0) && ((i / 2) % D == 0)) begin
                    sbq.push_back('{bank, AW'(addr), fmt(m, b1, data), cyc + 2});
                    addr++;
                end
                tick();
            end
            href = 1'b0;
            repeat (3) tick();
        end
        vs = 1'b1;
        repeat (5) tick();
    endtask

    initial begin
        int d0, e0, w0;
        rst_n = 1'b0; en = 1'b0; vs = 1'b1; href = 1'b0; data = '0;
        mode = '0; ack = 1'b0; ack_bank = 1'b0;
        repeat (3) tick();
        chk("rst_wr_en", 32'(wr_en), 32'd0);
        chk("rst_ready", 32'(ready), 32'd1);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_err", 32'(err), 32'd0);
        chk("rst_overrun", 32'(overrun), 32'd0);
        chk("rst_dropped", 32'(dropped), 32'd0);
        chk("rst_addr", 32'(wr_addr), 32'd0);
        chk("rst_data", 32'(wr_data), 32'd0);
        rst_n = 1'b1;
        en = 1'b1;
        repeat (2) tick();

        // Incrementing RGB565 frame into bank 0.
        for (int i = 0; i < 64; i++) fr_bytes[i] = 8'(i);
        d0 = done_cnt; w0 = wr_cnt;
        send_frame(4, 2'b00, 1'b0, 1'b1, -1, 0);
        chk("A_writes", 32'(wr_cnt - w0), 32'd8);
        chk("A_done", 32'(done_cnt - d0), 32'd1);
        chk("A_ready", 32'(ready), 32'd0);
        frame_ack(1'b0);

        // RGB444 into bank 1, first pair A5/3C.
        for (int i = 0; i < 64; i++) fr_bytes[i] = 8'($urandom);
        fr_bytes[0] = 8'hA5; fr_bytes[1] = 8'h3C;
        chk("B_first_fmt", 32'(fmt(2'b01, fr_bytes[0], fr_bytes[1])), 32'h053C);
        d0 = done_cnt;
        send_frame(4, 2'b01, 1'b1, 1'b1, -1, 0);
        chk("B_done", 32'(done_cnt - d0), 32'd1);
        chk("B_ready", 32'(ready), 32'd1);
        frame_ack(1'b1);

        // Y8 into bank 0, then mode 11 into bank 1: both banks now held.
        send_frame(4, 2'b10, 1'b0, 1'b1, -1, 0);
        chk("C_ready", 32'(ready), 32'd0);
        send_frame(4, 2'b11, 1'b1, 1'b1, -1, 0);
        chk("D_ready", 32'(ready), 32'd1);

        // No free bank: frame dropped.
        d0 = done_cnt; w0 = wr_cnt;
        send_frame(4, 2'b00, 1'b0, 1'b0, -1, 0);
        chk("E_writes", 32'(wr_cnt - w0), 32'd0);
        chk("E_done", 32'(done_cnt - d0), 32'd0);
        chk("E_overrun", 32'(overrun), 32'd1);
        chk("E_dropped", 32'(dropped), 32'd1);
        chk("E_ready", 32'(ready), 32'd1);

        // Short frame aborts; the same bank is reused by the next frame.
        frame_ack(1'b0);
        d0 = done_cnt; e0 = err_cnt; w0 = wr_cnt;
        send_frame(2, 2'b00, 1'b0, 1'b1, -1, 0);
        chk("F_writes", 32'(wr_cnt - w0), 32'd4);
        chk("F_err", 32'(err_cnt - e0), 32'd1);
        chk("F_done", 32'(done_cnt - d0), 32'd0);
        chk("F_ready", 32'(ready), 32'd1);
        d0 = done_cnt;
        send_frame(4, 2'b00, 1'b0, 1'b1, -1, 0);
        chk("G_done", 32'(done_cnt - d0), 32'd1);
        chk("G_ready", 32'(ready), 32'd0);

        // Enable dropped mid-line in bank 1.
        frame_ack(1'b1);
        w0 = wr_cnt;
        send_frame(4, 2'b00, 1'b1, 1'b1, 4, 1);
        tick();
        chk("H_wr_en_off", 32'(wr_en), 32'd0);
        chk("H_err_pulse", 32'(err), 32'd1);
        href = 1'b0; vs = 1'b1;
        tick();
        chk("H_err_single", 32'(err), 32'd0);
        chk("H_writes", 32'(wr_cnt - w0), 32'd1);
        chk("H_sb_empty", 32'(sbq.size()), 32'd0);
        en = 1'b1;
        repeat (2) tick();
        d0 = done_cnt;
        send_frame(4, 2'b00, 1'b1, 1'b1, -1, 0);
        chk("I_done", 32'(done_cnt - d0), 32'd1);
        chk("I_ready", 32'(ready), 32'd1);

        // Reset mid-frame.
        frame_ack(1'b0);
        send_frame(4, 2'b00, 1'b0, 1'b1, 20, 2);
        #1;
        chk("J_wr_en", 32'(wr_en), 32'd0);
        chk("J_ready", 32'(ready), 32'd1);
        chk("J_overrun", 32'(overrun), 32'd0);
        chk("J_dropped", 32'(dropped), 32'd0);
        chk("J_addr", 32'(wr_addr), 32'd0);
        chk("J_data", 32'(wr_data), 32'd0);
        chk("J_sb_empty", 32'(sbq.size()), 32'd0);
        href = 1'b0; vs = 1'b1;
        tick();
        rst_n = 1'b1;
        en = 1'b1;
        repeat (2) tick();
        d0 = done_cnt;
        send_frame(4, 2'b00, 1'b0, 1'b1, -1, 0);
        chk("K_done", 32'(done_cnt - d0), 32'd1);
        chk("K_ready", 32'(ready), 32'd0);
        chk("end_sb_empty", 32'(sbq.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/cam_capture_writer.md
CAM_CAPTURE_WRITER -- requirements
Module: cam_capture_writer

Interface
REQ-001 Parameter SRC_W, 640, source active pixels per line (even, multiple of DECIM).
REQ-002 Parameter SRC_H, 480, source active lines per frame (multiple of DECIM).
REQ-003 Parameter DECIM, 4, subsampling factor in both axes; legal values 1, 2, 4.
REQ-004 Parameter ADDR_W, 15, in-bank write address width; 2^ADDR_W >= (SRC_W/DECIM)*(SRC_H/DECIM).
REQ-005 Clk_i  in  1  camera pixel clock (PCLK); single clock domain.
REQ-006 Reset_i  in  1  reset; asynchronous, active-low.
REQ-007 Enable_i  in  1  capture enable (camera configuration done, pre-synchronised).
REQ-008 Vsync_i  in  1  camera VSYNC; high = vertical blanking.
REQ-009 Href_i  in  1  camera HREF; high = valid bytes on Data_i.
REQ-010 Data_i  in  8  camera byte bus.
REQ-011 Mode_i  in  2  pixel format: 00 RGB565, 01 RGB444, 10 Y8, 11 treated as 00.
REQ-012 Frame_Ack_i  in  1  one-cycle pulse: reader releases bank Ack_Bank_i (pre-synchronised).
REQ-013 Ack_Bank_i  in  1  bank being released.
REQ-014 Wr_En_o  out  1  frame-buffer write strobe.
REQ-015 Wr_Bank_o  out  1  bank of current write; memory address = {Wr_Bank_o, Wr_Addr_o}.
REQ-016 Wr_Addr_o  out  ADDR_W  in-bank pixel index, row-major.
REQ-017 Wr_Data_o  out  16  formatted pixel.
REQ-018 Frame_Done_o  out  1  one-cycle pulse: a complete frame is stored.
REQ-019 Ready_Bank_o  out  1  bank of the most recently completed frame.
REQ-020 Frame_Err_o  out  1  one-cycle pulse: frame aborted (short frame or Enable_i drop).
REQ-021 Overrun_o  out  1  sticky: at least one frame dropped for lack of a free bank.
REQ-022 Dropped_o  out  8  dropped-frame count, saturating at 255.

Function
REQ-023 Data_i, Href_i and Vsync_i SHALL be registered once before any use; all outputs SHALL be registered.
REQ-024 FSM states: IDLE, WAIT_VS, CAPTURE, DROP; IDLE->WAIT_VS when Enable_i=1; WAIT_VS->CAPTURE (target bank free) or DROP (target bank full) on registered-Vsync falling edge.
REQ-025 Target bank at frame start SHALL be the bank other than Ready_Bank_o; after reset, bank 0.
REQ-026 Mode_i SHALL be sampled at frame start and held for the frame.
REQ-027 Byte phase SHALL clear whenever registered Href is low; bytes alternate first/second while high; a source pixel completes on each second byte.
REQ-028 Source column counter SHALL clear on Href falling edge; source row counter SHALL increment on Href falling edge; bytes beyond SRC_W columns or SRC_H rows SHALL be ignored.
REQ-029 A source pixel SHALL be written only when column mod DECIM = 0 and row mod DECIM = 0.
REQ-030 Wr_Data_o: RGB565 {b1,b2}; RGB444 {4'h0,b1[3:0],b2}; Y8 {8'h00,b1}.
REQ-031 Wr_En_o SHALL pulse for one cycle exactly two cycles after the second byte is present on Data_i; Wr_Addr_o increments by 1 after each write, starting at 0 each frame.
REQ-032 CAPTURE: on Vsync rising edge, if row count = SRC_H, mark bank full, set Ready_Bank_o, pulse Frame_Done_o; else pulse Frame_Err_o, bank stays free; then ->WAIT_VS.
REQ-033 DROP: no writes; on Vsync rising edge set Overrun_o, increment Dropped_o (saturating), ->WAIT_VS.
REQ-034 Frame_Ack_i SHALL mark Ack_Bank_i free next cycle; ack of a free bank or the bank in CAPTURE SHALL be ignored.
REQ-035 Frame completion and ack in the same cycle SHALL both take effect.
REQ-036 Enable_i low in any state SHALL return to IDLE next cycle; in CAPTURE, pulse Frame_Err_o; bank flags unchanged.

Reset
REQ-037 Reset_i low SHALL asynchronously force IDLE, both banks free, Ready_Bank_o=1, all other outputs and counters 0; Overrun_o clears only on reset.

Verification (SRC_W=8, SRC_H=4, DECIM=2, ADDR_W=3)
REQ-038 RGB565 frame, bytes 0x00..0x3F -> 8 writes, addr 0..7, first data 0x0001, Frame_Done_o once, Ready_Bank_o=0.
REQ-039 Mode_i=01, first pair 0xA5,0x3C -> Wr_Data_o=0x053C; Mode_i=10 -> 0x00A5.
REQ-040 Three frames, no Frame_Ack_i -> banks 0 and 1 filled, third frame no writes, Overrun_o=1, Dropped_o=1.
REQ-041 Vsync rises after 2 of 4 lines -> Frame_Err_o pulse, no Frame_Done_o, next frame reuses same bank.
REQ-042 Enable_i dropped mid-line / Reset_i low mid-frame -> Wr_En_o=0 next cycle, FSM IDLE, reset values per REQ-037.
